// File: rtl/ysyx_22040210_pht_upd.sv
// Write-side engine for the gshare PHT: queues EXU branch-resolution updates, computes
// saturating 2-bit counters with forwarding from its own recent writes, and sweeps the
// table to INIT_VAL after reset or init_req.
// Latency: accept on edge k -> we=1 in cycle k+1 (fall-through when the queue is empty).
// Backpressure: upd_ready = NORM && !fifo_full; it does not depend on wr_gnt. While
// we && !wr_gnt, waddr/wdata are held stable.
// Ports: clk/rst (async active-low), upd_* (update request), init_req/busy (sweep control),
//        we/waddr/wdata/wr_gnt (PHT write port).

module ysyx_22040210_pht_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rptr[AW-1:0]];
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module ysyx_22040210_pht_upd #(
  parameter int         BHRLEN     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter int         HIST_NUM   = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [BHRLEN-1:0] upd_idx,
  input  logic              upd_taken,
  input  logic [1:0]        upd_ctr,
  input  logic              init_req,
  output logic              busy,
  output logic              we,
  output logic [BHRLEN-1:0] waddr,
  output logic [1:0]        wdata,
  input  logic              wr_gnt
);
  typedef struct packed {
    logic [BHRLEN-1:0] idx;
    logic              taken;
    logic [1:0]        ctr;
  } upd_t;

  typedef enum logic {S_INIT, S_NORM} state_t;

  localparam logic [BHRLEN-1:0] IDX_MAX = '1;

  state_t            state, state_d;
  logic [BHRLEN-1:0] sweep_idx, sweep_d;
  logic              we_d;
  logic [BHRLEN-1:0] waddr_d;
  logic [1:0]        wdata_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  upd_t              req, head, src;

  logic [HIST_NUM-1:0] hist_vld;
  logic [BHRLEN-1:0]   hist_idx [HIST_NUM];
  logic [1:0]          hist_val [HIST_NUM];
  logic                hist_push, hist_clr;

  logic       accept, load_en, complete;
  logic [1:0] base, new_ctr;

  assign busy      = (state == S_INIT);
  assign upd_ready = (state == S_NORM) && !fifo_full;
  // A request arriving with init_req is dropped; upd_ready only falls a cycle later.
  assign accept    = upd_valid && upd_ready && !init_req;
  assign complete  = we && wr_gnt;
  assign load_en   = !we || wr_gnt;
  assign req       = {upd_idx, upd_taken, upd_ctr};
  // Queued entries go first to keep strict order; otherwise the request falls through.
  assign src       = fifo_empty ? req : head;

  ysyx_22040210_pht_upd_fifo #(.W($bits(upd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat (req),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Counter base: the in-flight write beats history, younger history beats older,
  // and the fetch-time snapshot is the fallback.
  always_comb begin
    base = src.ctr;
    for (int i = HIST_NUM - 1; i >= 0; i--) begin
      if (hist_vld[i] && (hist_idx[i] == src.idx)) base = hist_val[i];
    end
    if (we && (waddr == src.idx)) base = wdata;
    if (src.taken) new_ctr = (base == 2'd3) ? 2'd3 : base + 2'd1;
    else           new_ctr = (base == 2'd0) ? 2'd0 : base - 2'd1;
  end

  always_comb begin
    state_d    = state;
    sweep_d    = sweep_idx;
    we_d       = we;
    waddr_d    = waddr;
    wdata_d    = wdata;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    hist_push  = 1'b0;
    hist_clr   = 1'b0;
    case (state)
      S_INIT: begin
        if (init_req) begin
          sweep_d = '0;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = INIT_VAL;
        end else if (complete) begin
          if (sweep_idx == IDX_MAX) begin
            state_d = S_NORM;
            sweep_d = '0;
            we_d    = 1'b0;
          end else begin
            sweep_d = sweep_idx + 1'b1;
            waddr_d = sweep_idx + 1'b1;
            wdata_d = INIT_VAL;
          end
        end else begin
          // Covers the first cycle after reset, when the output register is still empty.
          we_d    = 1'b1;
          waddr_d = sweep_idx;
          wdata_d = INIT_VAL;
        end
      end
      S_NORM: begin
        if (init_req) begin
          state_d    = S_INIT;
          sweep_d    = '0;
          fifo_flush = 1'b1;
          hist_clr   = 1'b1;
          we_d       = 1'b1;
          waddr_d    = '0;
          wdata_d    = INIT_VAL;
        end else begin
          hist_push = complete;
          if (load_en) begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              fifo_push = accept;
              we_d      = 1'b1;
              waddr_d   = head.idx;
              wdata_d   = new_ctr;
            end else if (accept) begin
              we_d    = 1'b1;
              waddr_d = req.idx;
              wdata_d = new_ctr;
            end else begin
              we_d = 1'b0;
            end
          end else begin
            fifo_push = accept;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      sweep_idx <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      state     <= state_d;
      sweep_idx <= sweep_d;
      we        <= we_d;
      waddr     <= waddr_d;
      wdata     <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_vld <= '0;
    end else if (hist_clr) begin
      hist_vld <= '0;
    end else if (hist_push) begin
      hist_vld <= {hist_vld[HIST_NUM-2:0], 1'b1};
    end
  end

  // Entry 0 is the youngest completed write.
  always_ff @(posedge clk) begin
    if (hist_push) begin
      for (int i = HIST_NUM - 1; i > 0; i--) begin
        hist_idx[i] <= hist_idx[i-1];
        hist_val[i] <= hist_val[i-1];
      end
      hist_idx[0] <= waddr;
      hist_val[0] <= wdata;
    end
  end
endmodule

// File: tb/tb_ysyx_22040210_pht_upd.sv
module tb_ysyx_22040210_pht_upd;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_taken = 1'b0;
  logic       init_req = 1'b0;
  logic       wr_gnt = 1'b1;
  logic [7:0] upd_idx = '0;
  logic [1:0] upd_ctr = '0;
  logic       upd_ready, busy, we;
  logic [7:0] waddr;
  logic [1:0] wdata;

  always #5 clk = ~clk;

  ysyx_22040210_pht_upd #(
    .BHRLEN(8), .FIFO_DEPTH(4), .HIST_NUM(4), .INIT_VAL(2'b01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .upd_ctr   (upd_ctr),
    .init_req  (init_req),
    .busy      (busy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .wr_gnt    (wr_gnt)
  );

  typedef struct { logic [7:0] idx; logic tk; logic [1:0] ctr; logic [1:0] exp; } vec_t;
  typedef struct { logic [7:0] idx; logic [1:0] val; } wr_t;

  wr_t        sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         sw_exp = 0, sw_cnt = 0, sw_err = 0, sw_cyc = 0, wr_cnt = 0;
  bit         acc_flag = 1'b0;
  logic [1:0] cur_exp = '0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    wr_t e, w;
    @(negedge clk);
    if (busy && we && wr_gnt) begin
      if (waddr != 8'(sw_exp) || wdata != 2'b01) sw_err++;
      sw_exp++;
      sw_cnt++;
    end
    if (busy && we) sw_cyc++;
    if (!busy && we && wr_gnt) begin
      wr_cnt++;
      if (sb_q.size() == 0) chk("sb_unexpected_write", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("sb_waddr", waddr, e.idx);
        chk("sb_wdata", wdata, e.val);
      end
    end
    if (upd_valid && upd_ready && !init_req) begin
      acc_flag = 1'b1;
      w.idx = upd_idx;
      w.val = cur_exp;
      sb_q.push_back(w);
    end
    if (init_req) begin
      sb_q.delete();
      sw_exp = 0;
      sw_cnt = 0;
      sw_cyc = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, int'(busy), 0);
    chk({tag, "_count"}, sw_cnt, 256);
    chk({tag, "_order"}, sw_err, 0);
    chk({tag, "_cycles"}, sw_cyc, 256);
    chk({tag, "_ready"}, int'(upd_ready), 1);
    chk({tag, "_we_off"}, int'(we), 0);
  endtask

  task automatic send(input vec_t v);
    upd_valid = 1'b1;
    upd_idx   = v.idx;
    upd_taken = v.tk;
    upd_ctr   = v.ctr;
    cur_exp   = v.exp;
    acc_flag  = 1'b0;
    for (int n = 0; n < 50 && !acc_flag; n++) step();
    upd_valid = 1'b0;
    chk("send_accept", int'(acc_flag), 1);
  endtask

  initial begin
    vec_t vt[10];
    vec_t v4[5];
    vec_t v5[3];
    vec_t vp[2];
    int   n, n0;

    vt[0] = '{8'h12, 1'b1, 2'd2, 2'd3};
    vt[1] = '{8'h13, 1'b1, 2'd3, 2'd3};
    vt[2] = '{8'h14, 1'b0, 2'd0, 2'd0};
    vt[3] = '{8'h40, 1'b1, 2'd1, 2'd2};
    vt[4] = '{8'h40, 1'b1, 2'd1, 2'd3};
    vt[5] = '{8'h40, 1'b1, 2'd1, 2'd3};
    vt[6] = '{8'h41, 1'b0, 2'd3, 2'd2};
    vt[7] = '{8'h41, 1'b0, 2'd3, 2'd1};
    vt[8] = '{8'h12, 1'b0, 2'd1, 2'd0};
    vt[9] = '{8'h41, 1'b1, 2'd0, 2'd2};
    v4[0] = '{8'h60, 1'b1, 2'd1, 2'd2};
    v4[1] = '{8'h61, 1'b1, 2'd1, 2'd2};
    v4[2] = '{8'h60, 1'b1, 2'd1, 2'd3};
    v4[3] = '{8'h62, 1'b0, 2'd2, 2'd1};
    v4[4] = '{8'h60, 1'b0, 2'd0, 2'd2};
    v5[0] = '{8'h50, 1'b1, 2'd1, 2'd2};
    v5[1] = '{8'h51, 1'b1, 2'd1, 2'd2};
    v5[2] = '{8'h52, 1'b1, 2'd1, 2'd2};
    vp[0] = '{8'h05, 1'b0, 2'd3, 2'd2};
    vp[1] = '{8'h40, 1'b1, 2'd0, 2'd1};

    // Reset values
    #12;
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(upd_ready), 0);

    // Initial sweep
    @(posedge clk);
    #1;
    rst = 1'b1;
    sw_exp = 0; sw_cnt = 0; sw_cyc = 0; sw_err = 0;
    run_sweep("sweep1");

    // Single and back-to-back updates with forwarding
    for (int i = 0; i < 10; i++) begin
      send(vt[i]);
      chk($sformatf("vec%0d_we", i), int'(we), 1);
      chk($sformatf("vec%0d_waddr", i), int'(waddr), int'(vt[i].idx));
      chk($sformatf("vec%0d_wdata", i), int'(wdata), int'(vt[i].exp));
    end
    step();
    step();
    chk("vec_drain", sb_q.size(), 0);

    // Backpressure: capacity FIFO_DEPTH+1, then in-order drain
    wr_gnt = 1'b0;
    for (int i = 0; i < 5; i++) send(v4[i]);
    chk("full_ready", int'(upd_ready), 0);
    upd_valid = 1'b1;
    upd_idx   = 8'h70;
    cur_exp   = 2'd0;
    acc_flag  = 1'b0;
    step();
    step();
    upd_valid = 1'b0;
    chk("full_reject", int'(acc_flag), 0);
    chk("hold_we", int'(we), 1);
    chk("hold_waddr", int'(waddr), 8'h60);
    chk("hold_wdata", int'(wdata), 2);
    wr_gnt = 1'b1;
    n0 = wr_cnt;
    repeat (5) step();
    chk("drain_cnt", wr_cnt - n0, 5);
    chk("drain_empty", sb_q.size(), 0);
    chk("drain_idle_we", int'(we), 0);

    // init_req with queued, ungranted updates
    wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) send(v5[i]);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("reinit_busy", int'(busy), 1);
    chk("reinit_ready", int'(upd_ready), 0);
    chk("reinit_waddr", int'(waddr), 0);
    sw_err = 0;
    wr_gnt = 1'b1;
    run_sweep("sweep2");
    for (int i = 0; i < 2; i++) begin
      send(vp[i]);
      chk($sformatf("post_init%0d_waddr", i), int'(waddr), int'(vp[i].idx));
      chk($sformatf("post_init%0d_wdata", i), int'(wdata), int'(vp[i].exp));
    end
    step();
    step();
    chk("post_init_drain", sb_q.size(), 0);

    // Async reset mid-sweep, then init_req restart inside INIT
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    sw_err = 0;
    n = 0;
    while (sw_cnt < 100 && n < 500) begin
      step();
      n++;
    end
    chk("pre_rst_waddr", int'(waddr), 100);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", int'(we), 0);
    chk("arst_waddr", int'(waddr), 0);
    chk("arst_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sw_exp = 0; sw_cnt = 0; sw_cyc = 0; sw_err = 0;
    n = 0;
    while (sw_cnt < 20 && n < 500) begin
      step();
      n++;
    end
    chk("restart_reach", sw_cnt, 20);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    run_sweep("sweep3");

    step();
    chk("final_q_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
